// File: rtl/ula_arbiter.sv
// Two-port round-robin arbiter in front of a 4-bit ALU, with a registered result and a 7-segment decode.
// Define ULA_ARBITER_ITERDIV_EN to replace the combinational divider with a 4-cycle restoring divider.
module ula_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic       err,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] led
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state, state_nxt;
  logic       pend, gnt, prio, sel1, take, exec_last, ill, dz;
  logic [3:0] ca, cb, alu;
  logic [2:0] cop;

  // prio high means port 1 wins a tie; a request is granted at its sampling edge
  // and the FSM leaves IDLE one edge later.
  assign sel1 = req1 & (~req0 | prio);
  assign take = (state == IDLE) & ~pend & (req0 | req1);
  assign ill  = cop[2] & cop[1];
  assign dz   = (cop == 3'd5) & (cb == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      gnt  <= 1'b0;
      prio <= 1'b0;
      ca   <= '0;
      cb   <= '0;
      cop  <= '0;
    end else if (take) begin
      pend <= 1'b1;
      gnt  <= sel1;
      prio <= ~sel1;
      ca   <= sel1 ? a1 : a0;
      cb   <= sel1 ? b1 : b0;
      cop  <= sel1 ? op1 : op0;
    end else if (state == IDLE) begin
      pend <= 1'b0;
    end
  end

`ifdef ULA_ARBITER_ITERDIV_EN
  logic [1:0] cnt;
  logic [3:0] dq, rem, q_next;
  logic [4:0] part;
  logic [5:0] trial;
  logic       fits;

  assign part   = {rem, dq[3]};
  assign trial  = {1'b0, part} - {2'b00, cb};
  assign fits   = ~trial[5];
  assign q_next = {dq[2:0], fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dq  <= '0;
      rem <= '0;
    end else if (take) begin
      cnt <= '0;
      dq  <= sel1 ? a1 : a0;
      rem <= '0;
    end else if (state == EXEC) begin
      cnt <= cnt + 2'd1;
      dq  <= q_next;
      rem <= fits ? trial[3:0] : part[3:0];
    end
  end

  assign exec_last = (cop != 3'd5) | (cnt == 2'd3);
`else
  assign exec_last = 1'b1;
`endif

  always_comb begin
    alu = '0;
    case (cop)
      3'd0: alu = ca & cb;
      3'd1: alu = ca | cb;
      3'd2: alu = ca + cb;
      3'd3: alu = ca - cb;
      3'd4: alu = ca * cb;
`ifdef ULA_ARBITER_ITERDIV_EN
      3'd5: alu = dz ? 4'hF : q_next;
`else
      3'd5: alu = dz ? 4'hF : ca / cb;
`endif
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == EXEC && exec_last) begin
        if (ill) begin
          err <= 1'b1;
        end else begin
          result <= alu;
          err    <= dz;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend) state_nxt = EXEC;
      EXEC:    if (exec_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign done0 = (state == DONE) & ~gnt;
  assign done1 = (state == DONE) & gnt;
  assign busy  = (state != IDLE);
  assign led   = result;

  always_comb begin
    seg = 7'b1111111;
    case (result)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      default: seg = 7'b1111111;
    endcase
  end

endmodule
